// File: rtl/mult_div_pkg.sv
// Shared types and default widths for the mult_div restoring divider.
package mult_div_pkg;

  localparam int A_W   = 16;
  localparam int B_W   = 32;
  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = $clog2(B_W);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] prem,
  input  logic         din,
  input  logic [W-1:0] d,
  output logic [W-1:0] rem_next,
  output logic         q
);

  logic [W:0]   t;
  logic [W-1:0] diff;

  // prem < d always holds, so t < 2*d and t-d fits in W bits when q is set.
  assign t        = {prem, din};
  assign q        = (t >= {1'b0, d});
  assign diff     = t[W-1:0] - d;
  assign rem_next = q ? diff : t[W-1:0];

endmodule

// File: rtl/mult_div.sv
// Sequential restoring divider undoing the 16x32 multiplier, one quotient bit per clock.
// Optional MULT_DIV_BYPASS_EN lets a new operation be accepted on the edge a result is consumed.
module mult_div
  import mult_div_pkg::*;
#(
  parameter  int A_WIDTH = A_W,
  parameter  int B_WIDTH = B_W,
  localparam int P_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [P_WIDTH-1:0] p,
  input  logic [A_WIDTH-1:0] a,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [B_WIDTH-1:0] b,
  output logic [A_WIDTH-1:0] rem,
  output logic               div_zero,
  output logic               ovf
);

  localparam int CW = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;

  state_t             state;
  logic [A_WIDTH-1:0] div_reg;
  logic [A_WIDTH-1:0] prem_reg;
  logic [B_WIDTH-1:0] sr_reg;
  logic [CW-1:0]      cnt_reg;
  logic [A_WIDTH-1:0] step_rem;
  logic               step_q;
  logic [A_WIDTH-1:0] p_hi;
  logic               accept;

  assign p_hi = p[P_WIDTH-1:B_WIDTH];

`ifdef MULT_DIV_BYPASS_EN
  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
`else
  assign in_ready = (state == IDLE);
`endif

  assign accept = in_valid & in_ready;

  // sr_reg shifts dividend bits out of the top while quotient bits enter at the bottom.
  div_step #(.W(A_WIDTH)) u_step (
    .prem     (prem_reg),
    .din      (sr_reg[B_WIDTH-1]),
    .d        (div_reg),
    .rem_next (step_rem),
    .q        (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      b         <= '0;
      rem       <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
      div_reg   <= '0;
      prem_reg  <= '0;
      sr_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state)
        CALC: begin
          prem_reg <= step_rem;
          sr_reg   <= {sr_reg[B_WIDTH-2:0], step_q};
          if (cnt_reg == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            b         <= {sr_reg[B_WIDTH-2:0], step_q};
            rem       <= step_rem;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
          // A later assignment here overrides the consume above when bypass accepts.
          if (accept) begin
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            div_reg  <= a;
            if (a == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              div_zero  <= 1'b1;
              b         <= '1;
              rem       <= '0;
            end else if (p_hi >= a) begin
              state     <= DONE;
              out_valid <= 1'b1;
              ovf       <= 1'b1;
              b         <= '1;
              rem       <= '0;
            end else begin
              state    <= CALC;
              prem_reg <= p_hi;
              sr_reg   <= p[B_WIDTH-1:0];
              cnt_reg  <= CW'(B_WIDTH - 1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Randomized bench for mult_div: a division-based reference model and scoreboard
// checked every cycle, plus directed cases with hand-computed results.
module tb_mult_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] p = '0;
  logic [15:0] a = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] b;
  logic [15:0] rem;
  logic        div_zero;
  logic        ovf;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int or_mode = 0;  // 0: out_ready low, 1: high, 2: random

  typedef struct {
    logic [47:0] p;
    logic [15:0] a;
    logic [31:0] b;
    logic [15:0] r;
    logic        dz;
    logic        ov;
    int          due;
  } exp_t;

  exp_t sb[$];

  mult_div dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .p(p), .a(a), .out_valid(out_valid), .out_ready(out_ready),
    .b(b), .rem(rem), .div_zero(div_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (or_mode == 2) out_ready = $urandom_range(0, 1) == 1;
    else out_ready = (or_mode == 1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Plain long division; the accept edge is the one after the sampling negedge.
  function automatic exp_t model(input logic [47:0] pp, input logic [15:0] aa, input int c);
    exp_t e;
    logic [47:0] q48;
    e.p = pp; e.a = aa; e.dz = 1'b0; e.ov = 1'b0;
    if (aa == 16'd0) begin
      e.dz = 1'b1; e.b = '1; e.r = '0; e.due = c + 1;
    end else begin
      q48 = pp / {32'd0, aa};
      if (q48 > 48'h0000_FFFF_FFFF) begin
        e.ov = 1'b1; e.b = '1; e.r = '0; e.due = c + 1;
      end else begin
        e.b = q48[31:0];
        e.r = 16'(pp % {32'd0, aa});
        e.due = c + 1 + 32;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    bit   due_now;
    logic exp_rdy;
    if (!rst) begin
      due_now = (sb.size() > 0) && (cyc >= sb[0].due);
`ifdef MULT_DIV_BYPASS_EN
      exp_rdy = (sb.size() == 0) || (due_now && out_ready);
`else
      exp_rdy = (sb.size() == 0);
`endif
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(due_now));
      if (due_now) begin
        chk("b", 64'(b), 64'(sb[0].b));
        chk("rem", 64'(rem), 64'(sb[0].r));
        chk("div_zero", 64'(div_zero), 64'(sb[0].dz));
        chk("ovf", 64'(ovf), 64'(sb[0].ov));
        if (out_ready) begin
          $display("op p=%h a=%h -> b=%h rem=%h dz=%0d ovf=%0d", sb[0].p, sb[0].a, b, rem, div_zero, ovf);
          void'(sb.pop_front());
        end
      end
      if (in_valid && exp_rdy) sb.push_back(model(p, a, cyc));
    end
  end

  task automatic send(input logic [47:0] pp, input logic [15:0] aa);
    bit acc;
    int guard = 0;
    in_valid = 1'b1; p = pp; a = aa;
    forever begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #2;
      if (acc) break;
      guard++;
      if (guard > 2000) begin chk("send_timeout", 64'd0, 64'd1); break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int guard = 0;
    while (sb.size() != 0 && guard < 5000) begin @(negedge clk); guard++; end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk); #2;
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) chk("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic directed(input string nm, input logic [47:0] pp, input logic [15:0] aa,
                          input logic [31:0] eb, input logic [15:0] er,
                          input logic edz, input logic eov, input int elat);
    int  acc_cyc;
    bit  seen;
    or_mode = 0;
    send(pp, aa);
    acc_cyc = cyc;
    wait_valid(seen);
    if (seen) begin
      chk({nm, "_latency"}, 64'(cyc - acc_cyc + 1), 64'(elat));
      chk({nm, "_b"}, 64'(b), 64'(eb));
      chk({nm, "_rem"}, 64'(rem), 64'(er));
      chk({nm, "_div_zero"}, 64'(div_zero), 64'(edz));
      chk({nm, "_ovf"}, 64'(ovf), 64'(eov));
      if (!edz && !eov) chk({nm, "_invariant"}, 64'(b) * 64'(aa) + 64'(rem), 64'(pp));
    end
    or_mode = 1;
    wait_empty();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int  acc_c [3];
    bit  seen;
    logic [15:0] ra;
    logic [31:0] rb;
    logic [47:0] rp;

    #3;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_b", 64'(b), 64'd0);
    chk("reset_rem", 64'(rem), 64'd0);
    chk("reset_flags", 64'({div_zero, ovf}), 64'd0);
    @(posedge clk); #2; rst = 1'b0;
    @(posedge clk); #2;

    directed("d600", 48'd600, 16'd7, 32'd85, 16'd5, 1'b0, 1'b0, 33);
    directed("dmax", 48'hFFFE_FFFF_0001, 16'hFFFF, 32'hFFFF_FFFF, 16'd0, 1'b0, 1'b0, 33);
    directed("dzero", 48'h1234_5678_9ABC, 16'd0, 32'hFFFF_FFFF, 16'd0, 1'b1, 1'b0, 1);
    directed("dovf", 48'h1_0000_0000, 16'd1, 32'hFFFF_FFFF, 16'd0, 1'b0, 1'b1, 1);
    directed("dzero_ovfp", 48'hFFFF_0000_0000, 16'd0, 32'hFFFF_FFFF, 16'd0, 1'b1, 1'b0, 1);

    // Result held with out_ready low while a competing request is offered.
    or_mode = 0;
    send(48'd1_000_000_007, 16'd1000);
    wait_valid(seen);
    @(posedge clk); #2;
    in_valid = 1'b1; p = 48'd5; a = 16'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_b", 64'(b), 64'd1_000_000);
      chk("hold_rem", 64'(rem), 64'd7);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #2; in_valid = 1'b0;
    or_mode = 1;
    wait_empty();

    // Asynchronous reset in the middle of a calculation.
    send(48'h0000_ABCD_1234, 16'd77);
    for (int i = 0; i < 12; i++) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_b", 64'(b), 64'd0);
    sb.delete();
    @(posedge clk); #2; rst = 1'b0;
    @(posedge clk); #2;
    directed("post_rst", 48'd100, 16'd10, 32'd10, 16'd0, 1'b0, 1'b0, 33);

    // Back-to-back accept spacing with out_ready held high.
    or_mode = 1;
    @(posedge clk); #2;
    for (int i = 0; i < 3; i++) begin
      send(48'd123_456_789 + 48'(i), 16'd321);
      acc_c[i] = cyc;
    end
`ifdef MULT_DIV_BYPASS_EN
    chk("period_0", 64'(acc_c[1] - acc_c[0]), 64'd33);
    chk("period_1", 64'(acc_c[2] - acc_c[1]), 64'd33);
`else
    chk("period_0", 64'(acc_c[1] - acc_c[0]), 64'd34);
    chk("period_1", 64'(acc_c[2] - acc_c[1]), 64'd34);
`endif
    wait_empty();

    or_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(1, 16'hFFFF));
      rb = $urandom;
      rp = 48'(ra) * 48'(rb) + 48'($urandom % 32'(ra));
      if (i % 97 == 0) ra = 16'd0;
      send(rp, ra);
    end
    or_mode = 1;
    wait_empty();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
